fir_avg_decim_out: RTL and testbench

Downstream stage of the 4-tap moving-average FIR. It takes the FIR's 24-bit signed output every enabled clock and discards the pipeline warm-up samples. It then decimates by DECIM, rounds/saturates to 16 bits and buffers the results in a small FIFO. Consumers read the FIFO through a valid/ready stream interface, such as a bus bridge or DMA packer.

---
 rtl/fir_avg_pkg.sv | 19 +
 rtl/fir_sync_fifo.sv | 56 +++++
 rtl/fir_avg_decim_out.sv | 127 ++++++++++++
 tb/tb_fir_avg_decim_out.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_avg_pkg.sv
// Shared types and constants for the moving-average FIR output stage.
package fir_avg_pkg;

  localparam int FIR_DOUT_W = 24;
  localparam int SAMPLE_W   = 16;

  typedef enum logic {WARM, RUN} state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead single-clock FIFO; a push into a full FIFO is taken only when a pop frees a slot
// in the same cycle. While empty, data_o repeats the last popped word.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  assign data_o = empty_o ? last_q : mem[rd_ptr_q];

endmodule

// File: rtl/fir_avg_decim_out.sv
// FIR output stage: drop warm-up samples, decimate, round/saturate, then buffer
// results in a show-ahead FIFO read through a valid/ready stream.
module fir_avg_decim_out
  import fir_avg_pkg::*;
#(
  parameter int DIN_W      = FIR_DOUT_W,
  parameter int DOUT_W     = SAMPLE_W,
  parameter int SHIFT      = 0,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic signed [DIN_W-1:0]       din,
  input  logic                          clr_flags,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [DOUT_W-1:0]      m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky,
  output logic                          sat_sticky
);

  localparam int EW = DIN_W + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam state_t        RESET_STATE = (WARMUP > 0) ? WARM : RUN;
  localparam logic signed [EW-1:0] SAT_HI = EW'(sat_max(DOUT_W));
  localparam logic signed [EW-1:0] SAT_LO = EW'(sat_min(DOUT_W));

  state_t                   state_q, state_d;
  logic [WW-1:0]            warm_q, warm_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic                     select;
  logic signed [EW-1:0]     ext, t;
  logic                     sat_hi, sat_lo;
  logic signed [DOUT_W-1:0] sat_val;
  logic                     stage_valid_q;
  logic signed [DOUT_W-1:0] stage_data_q;
  logic                     ovf_q, ovf_d, sat_q, sat_d;
  logic                     ovf_set, sat_set;
  logic                     fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    phase_d = phase_q;
    select  = 1'b0;
    case (state_q)
      WARM: if (en) begin
        if (warm_q == WARM_LAST) state_d = RUN;
        warm_d = warm_q + 1'b1;
      end
      RUN: if (en) begin
        select  = (phase_q == '0);
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // One extra bit of headroom so the rounding offset can never wrap.
  assign ext = {din[DIN_W-1], din};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(1 << (SHIFT - 1));
      assign t = (ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign t = ext;
    end
  endgenerate

  assign sat_hi  = (t > SAT_HI);
  assign sat_lo  = (t < SAT_LO);
  assign sat_val = sat_hi ? DOUT_W'(SAT_HI) : (sat_lo ? DOUT_W'(SAT_LO) : t[DOUT_W-1:0]);

  // Full implies non-empty, so a pop is possible exactly when m_ready is high.
  assign sat_set = select & (sat_hi | sat_lo);
  assign ovf_set = stage_valid_q & fifo_full & ~m_ready;
  assign sat_d   = sat_set | (sat_q & ~clr_flags);
  assign ovf_d   = ovf_set | (ovf_q & ~clr_flags);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      warm_q        <= '0;
      phase_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      ovf_q         <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_q        <= warm_d;
      phase_q       <= phase_d;
      stage_valid_q <= select;
      if (select) stage_data_q <= sat_val;
      ovf_q         <= ovf_d;
      sat_q         <= sat_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stage_valid_q),
    .pop_i   (m_ready),
    .data_i  (stage_data_q),
    .data_o  (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign m_valid    = ~fifo_empty;
  assign ovf_sticky = ovf_q;
  assign sat_sticky = sat_q;

endmodule

// File: tb/tb_fir_avg_decim_out.sv
// Scoreboard bench for fir_avg_decim_out: three instances (DECIM=4; DECIM=1; DECIM=2 with SHIFT=8).
module tb_fir_avg_decim_out;

  logic clk = 1'b0;
  logic rst_n, clr;
  logic a_en, b_en, c_en;
  logic signed [23:0] a_din, b_din, c_din;
  logic a_ready, b_ready, c_ready;
  logic a_valid, b_valid, c_valid;
  logic signed [15:0] a_data, b_data, c_data;
  logic [3:0] a_level, b_level, c_level;
  logic a_ovf, b_ovf, c_ovf, a_sat, b_sat, c_sat;

  int errors = 0, checks = 0, cyc = 0;
  int first_a = -1, a_outs = 0, b_outs = 0, c_outs = 0;
  int qa[$], qb[$], qc[$];
  int warm_m[3], phase_m[3];
  localparam int DEC [3] = '{4, 1, 2};
  localparam int SH  [3] = '{0, 0, 8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_avg_decim_out u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .din(a_din), .clr_flags(clr),
    .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .fifo_level(a_level),
    .ovf_sticky(a_ovf), .sat_sticky(a_sat));

  fir_avg_decim_out #(.DECIM(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .din(b_din), .clr_flags(clr),
    .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .fifo_level(b_level),
    .ovf_sticky(b_ovf), .sat_sticky(b_sat));

  fir_avg_decim_out #(.DECIM(2), .SHIFT(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .din(c_din), .clr_flags(clr),
    .m_valid(c_valid), .m_ready(c_ready), .m_data(c_data), .fifo_level(c_level),
    .ovf_sticky(c_ovf), .sat_sticky(c_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int model_out(input int d, input int sh);
    longint t = d;
    if (sh > 0) t = (t + (longint'(1) << (sh - 1))) >>> sh;
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic reset_models();
    for (int i = 0; i < 3; i++) begin
      warm_m[i] = 0;
      phase_m[i] = 0;
    end
    qa.delete(); qb.delete(); qc.delete();
  endtask

  // Drive one cycle on an instance; expected outputs are queued here unless the sample is expected to be dropped.
  task automatic drive(input int inst, input bit e, input int d, input bit drop);
    int v;
    case (inst)
      0:       begin a_en = e; a_din = d[23:0]; end
      1:       begin b_en = e; b_din = d[23:0]; end
      default: begin c_en = e; c_din = d[23:0]; end
    endcase
    if (e) begin
      if (warm_m[inst] < 4) warm_m[inst]++;
      else begin
        if (phase_m[inst] == 0 && !drop) begin
          v = model_out(d, SH[inst]);
          case (inst)
            0:       qa.push_back(v);
            1:       qb.push_back(v);
            default: qc.push_back(v);
          endcase
        end
        phase_m[inst] = (phase_m[inst] + 1) % DEC[inst];
      end
    end
    tick(1);
  endtask

  // Output side: pop and compare on every handshake, plus hold check on stalled B.
  int e_pop;
  logic prev_bv = 1'b0, prev_br = 1'b0, prev_rst = 1'b0;
  logic signed [15:0] prev_bd = '0;
  always @(negedge clk) begin
    if (a_valid && first_a < 0) first_a = cyc;
    if (a_valid && a_ready) begin
      a_outs++;
      if (qa.size() == 0) chk("A_unexpected_out", qa.size(), 1);
      else begin e_pop = qa.pop_front(); chk("A_data", a_data, e_pop); end
    end
    if (b_valid && b_ready) begin
      b_outs++;
      if (qb.size() == 0) chk("B_unexpected_out", qb.size(), 1);
      else begin e_pop = qb.pop_front(); chk("B_data", b_data, e_pop); end
    end
    if (c_valid && c_ready) begin
      c_outs++;
      if (qc.size() == 0) chk("C_unexpected_out", qc.size(), 1);
      else begin e_pop = qc.pop_front(); chk("C_data", c_data, e_pop); end
    end
    if (rst_n && prev_rst && prev_bv && !prev_br) begin
      chk("B_hold_valid", b_valid, 1);
      chk("B_hold_data", b_data, prev_bd);
    end
    prev_bv = b_valid; prev_br = b_ready; prev_bd = b_data; prev_rst = rst_n;
  end

  int c0, base;
  initial begin
    rst_n = 1'b0; clr = 1'b0;
    a_en = 0; b_en = 0; c_en = 0; a_din = '0; b_din = '0; c_din = '0;
    a_ready = 0; b_ready = 0; c_ready = 0;
    reset_models();
    tick(3);
    chk("rst_A_valid", a_valid, 0);
    chk("rst_A_data", a_data, 0);
    chk("rst_A_level", a_level, 0);
    chk("rst_A_ovf", a_ovf, 0);
    chk("rst_A_sat", a_sat, 0);
    chk("rst_B_level", b_level, 0);
    chk("rst_C_valid", c_valid, 0);
    rst_n = 1'b1;
    tick(1);

    // Warm-up discard, decimate by 4, latency 2
    a_ready = 1;
    c0 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 5) c0 = cyc;
      drive(0, 1, n, 0);
    end
    a_en = 0;
    tick(4);
    chk("A_latency", first_a - c0, 2);
    chk("A_out_count", a_outs, 4);
    chk("A_drained", qa.size(), 0);
    chk("A_sat_clean", a_sat, 0);

    // Saturation at both rails, then clear
    while (phase_m[0] != 0) drive(0, 1, 0, 0);
    drive(0, 1, 36864, 0);
    while (phase_m[0] != 0) drive(0, 1, 0, 0);
    drive(0, 1, -40000, 0);
    a_en = 0;
    tick(4);
    chk("A_sat_drained", qa.size(), 0);
    chk("A_sat_set", a_sat, 1);
    chk("A_ovf_clean", a_ovf, 0);
    clr = 1; tick(1); clr = 0;
    chk("A_sat_cleared", a_sat, 0);

    // Backpressure overflow with DECIM=1
    b_ready = 0;
    for (int i = 0; i < 4; i++) drive(1, 1, i, 0);
    for (int i = 0; i < 12; i++) drive(1, 1, 100 + i, i >= 8);
    b_en = 0;
    tick(2);
    chk("B_full_level", b_level, 8);
    chk("B_ovf_set", b_ovf, 1);
    chk("B_full_valid", b_valid, 1);
    chk("B_head_data", b_data, 100);
    clr = 1; tick(1); clr = 0;
    chk("B_ovf_cleared", b_ovf, 0);

    // Full FIFO with a pop in the same cycle as the stage write
    drive(1, 1, 200, 0);
    b_en = 0; b_ready = 1;
    tick(1);
    b_ready = 0;
    tick(1);
    chk("B_fullpop_level", b_level, 8);
    chk("B_fullpop_ovf", b_ovf, 0);
    b_ready = 1;
    tick(12);
    chk("B_out_count", b_outs, 9);
    chk("B_drained", qb.size(), 0);
    chk("B_empty_level", b_level, 0);
    chk("B_empty_valid", b_valid, 0);
    chk("B_hold_last", b_data, 200);

    // en gating with DECIM=2, SHIFT=8
    c_ready = 1;
    for (int i = 0; i < 16; i++) drive(2, (i % 2) == 0, (i + 1) * 256, 0);
    c_en = 0;
    tick(4);
    chk("C_gate_count", c_outs, 2);
    chk("C_gate_drained", qc.size(), 0);

    // Round-half-up and rounding into saturation
    while (phase_m[2] != 0) drive(2, 1, 0, 0);
    drive(2, 1, 384, 0);  drive(2, 1, 0, 0);
    drive(2, 1, -384, 0); drive(2, 1, 0, 0);
    drive(2, 1, -385, 0); drive(2, 1, 0, 0);
    drive(2, 1, 8388607, 0); drive(2, 1, 0, 0);
    c_en = 0;
    tick(4);
    chk("C_round_count", c_outs, 6);
    chk("C_round_drained", qc.size(), 0);
    chk("C_sat_set", c_sat, 1);

    // Asynchronous reset mid-stream with five buffered samples
    b_ready = 0;
    drive(1, 1, 40000, 0);
    for (int i = 1; i <= 4; i++) drive(1, 1, i, 0);
    b_en = 0;
    tick(2);
    chk("B_pre_rst_level", b_level, 5);
    chk("B_pre_rst_sat", b_sat, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("B_async_valid", b_valid, 0);
    chk("B_async_level", b_level, 0);
    chk("B_async_sat", b_sat, 0);
    chk("B_async_ovf", b_ovf, 0);
    chk("C_async_sat", c_sat, 0);
    reset_models();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    b_ready = 1;
    base = b_outs;
    for (int i = 0; i < 4; i++) drive(1, 1, 50 + i, 0);
    drive(1, 1, 77, 0);
    drive(1, 1, 78, 0);
    b_en = 0;
    tick(4);
    chk("B_post_rst_outs", b_outs - base, 2);
    chk("B_post_rst_drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
